mem_access_stage: RTL

- Pipeline MEM stage between the EX/MEM register and the MEM/WB register.
- Decodes the 20-bit instruction in EX/MEM. Loads and stores go to data memory over a req/ack handshake; all other instructions pass straight through.
- Stalls the upstream pipeline while a memory access is outstanding.
- Presents registered results (ALU result, load data, operands, instruction) to MEM/WB each cycle.

---
 rtl/mem_access_stage.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Pipeline MEM stage sitting between the EX/MEM and MEM/WB registers.
// Non-memory instructions are registered straight through with one cycle of
// latency. Loads and stores are captured into holding registers and issued to
// data memory over a req/ack handshake; the upstream pipeline is stalled while
// the access is outstanding. An access that sees no ack within TIMEOUT cycles
// is abandoned: it retires with zero read data and a one-cycle mem_timeout.
//
// Ports:
//   clock, reset          pipeline clock, synchronous active-high reset
//   valid_in              EX/MEM holds a valid instruction
//   instruction_in        instruction (opcode in the top 5 bits)
//   aluRESULT_in          ALU result, also the load/store address
//   dataRFOut1_in         register-file operand 1
//   dataRFOut2_in         register-file operand 2, also the store data
//   mem_rdata, mem_ack    data-memory read data and one-cycle completion pulse
//   mem_req, mem_we       memory request (held until ack/timeout), 1 = store
//   mem_addr, mem_wdata   access address and store data
//   stall                 upstream must hold EX/MEM and PC
//   valid_out             MEM/WB inputs carry a retired instruction this cycle
//   instruction_out, aluRESULT_out, memory_read_data,
//   dataRFOut1_out, dataRFOut2_out   registered MEM/WB payload
//   mem_timeout           one-cycle pulse when an access is abandoned
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int          DATA_W   = 20,
    parameter logic [4:0]  OP_LOAD  = 5'b00110,
    parameter logic [4:0]  OP_STORE = 5'b00111,
    parameter int          TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] instruction_in,
    input  logic [DATA_W-1:0] aluRESULT_in,
    input  logic [DATA_W-1:0] dataRFOut1_in,
    input  logic [DATA_W-1:0] dataRFOut2_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              valid_out,
    output logic [DATA_W-1:0] instruction_out,
    output logic [DATA_W-1:0] aluRESULT_out,
    output logic [DATA_W-1:0] memory_read_data,
    output logic [DATA_W-1:0] dataRFOut1_out,
    output logic [DATA_W-1:0] dataRFOut2_out,
    output logic              mem_timeout
);

    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;

    // Holding registers for the instruction that owns the outstanding access.
    logic [DATA_W-1:0] hold_instr_r, hold_instr_s;
    logic [DATA_W-1:0] hold_alu_r,   hold_alu_s;
    logic [DATA_W-1:0] hold_op1_r,   hold_op1_s;
    logic [DATA_W-1:0] hold_op2_r,   hold_op2_s;
    logic              hold_load_r,  hold_load_s;

    // Registered outputs.
    logic              mem_req_r,   mem_req_s;
    logic              mem_we_r,    mem_we_s;
    logic [DATA_W-1:0] mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              valid_out_r, valid_out_s;
    logic [DATA_W-1:0] instr_out_r, instr_out_s;
    logic [DATA_W-1:0] alu_out_r,   alu_out_s;
    logic [DATA_W-1:0] rdata_out_r, rdata_out_s;
    logic [DATA_W-1:0] op1_out_r,   op1_out_s;
    logic [DATA_W-1:0] op2_out_r,   op2_out_s;
    logic              timeout_r,   timeout_s;

    logic [4:0] opcode_s;
    logic       is_load_s;
    logic       is_store_s;

    assign opcode_s   = instruction_in[DATA_W-1 -: 5];
    assign is_load_s  = (opcode_s == OP_LOAD);
    assign is_store_s = (opcode_s == OP_STORE);

    // Next-state and next-output decode for the IDLE / WAIT_ACK controller.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        hold_instr_s = hold_instr_r;
        hold_alu_s   = hold_alu_r;
        hold_op1_s   = hold_op1_r;
        hold_op2_s   = hold_op2_r;
        hold_load_s  = hold_load_r;
        mem_req_s    = mem_req_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        valid_out_s  = 1'b0;
        instr_out_s  = instr_out_r;
        alu_out_s    = alu_out_r;
        rdata_out_s  = rdata_out_r;
        op1_out_s    = op1_out_r;
        op2_out_s    = op2_out_r;
        timeout_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (valid_in) begin
                    if (is_load_s || is_store_s) begin
                        hold_instr_s = instruction_in;
                        hold_alu_s   = aluRESULT_in;
                        hold_op1_s   = dataRFOut1_in;
                        hold_op2_s   = dataRFOut2_in;
                        hold_load_s  = is_load_s;
                        mem_req_s    = 1'b1;
                        mem_we_s     = is_store_s;
                        mem_addr_s   = aluRESULT_in;
                        mem_wdata_s  = dataRFOut2_in;
                        cnt_s        = CNT_ZERO;
                        state_s      = ST_WAIT_ACK;
                    end else begin
                        instr_out_s  = instruction_in;
                        alu_out_s    = aluRESULT_in;
                        op1_out_s    = dataRFOut1_in;
                        op2_out_s    = dataRFOut2_in;
                        rdata_out_s  = DATA_ZERO;
                        valid_out_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                // Ack is checked first so that an ack on the last allowed
                // cycle still completes normally instead of timing out.
                if (mem_ack || (cnt_r == CNT_LAST)) begin
                    state_s     = ST_IDLE;
                    mem_req_s   = 1'b0;
                    valid_out_s = 1'b1;
                    instr_out_s = hold_instr_r;
                    alu_out_s   = hold_alu_r;
                    op1_out_s   = hold_op1_r;
                    op2_out_s   = hold_op2_r;
                    if (mem_ack) begin
                        rdata_out_s = hold_load_r ? mem_rdata : DATA_ZERO;
                        timeout_s   = 1'b0;
                    end else begin
                        rdata_out_s = DATA_ZERO;
                        timeout_s   = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State, holding and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            hold_instr_r <= DATA_ZERO;
            hold_alu_r   <= DATA_ZERO;
            hold_op1_r   <= DATA_ZERO;
            hold_op2_r   <= DATA_ZERO;
            hold_load_r  <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= DATA_ZERO;
            mem_wdata_r  <= DATA_ZERO;
            valid_out_r  <= 1'b0;
            instr_out_r  <= DATA_ZERO;
            alu_out_r    <= DATA_ZERO;
            rdata_out_r  <= DATA_ZERO;
            op1_out_r    <= DATA_ZERO;
            op2_out_r    <= DATA_ZERO;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            hold_instr_r <= hold_instr_s;
            hold_alu_r   <= hold_alu_s;
            hold_op1_r   <= hold_op1_s;
            hold_op2_r   <= hold_op2_s;
            hold_load_r  <= hold_load_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            valid_out_r  <= valid_out_s;
            instr_out_r  <= instr_out_s;
            alu_out_r    <= alu_out_s;
            rdata_out_r  <= rdata_out_s;
            op1_out_r    <= op1_out_s;
            op2_out_r    <= op2_out_s;
            timeout_r    <= timeout_s;
        end
    end

    // Stall comes from the state register alone, so there is no
    // combinational path from mem_ack back into the upstream pipeline.
    assign stall            = (state_r == ST_WAIT_ACK);
    assign mem_req          = mem_req_r;
    assign mem_we           = mem_we_r;
    assign mem_addr         = mem_addr_r;
    assign mem_wdata        = mem_wdata_r;
    assign valid_out        = valid_out_r;
    assign instruction_out  = instr_out_r;
    assign aluRESULT_out    = alu_out_r;
    assign memory_read_data = rdata_out_r;
    assign dataRFOut1_out   = op1_out_r;
    assign dataRFOut2_out   = op2_out_r;
    assign mem_timeout      = timeout_r;

endmodule
